// File: rtl/serial_adder_unit_pkg.sv
// Shared constants for the bit-serial arithmetic units: FSM state encodings
// and the add/subtract opcode values, reused by the iterative multiply/divide units.
package serial_adder_unit_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic OpAdd = 1'b0;
  localparam logic OpSub = 1'b1;

  // Bit-counter width able to hold the values 0..width.
  function automatic int unsigned count_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_adder_unit_full_adder.sv
// Single-bit full adder cell: one evaluation per clock in the serial adder.
module serial_adder_unit_full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic sum_o,
  output logic carry_o
);

  logic half_sum;

  // Sum and carry of three single-bit inputs.
  always_comb begin
    half_sum = a_i ^ b_i;
    sum_o    = half_sum ^ c_i;
    carry_o  = (a_i & b_i) | (c_i & half_sum);
  end

endmodule

// File: rtl/serial_adder_unit.sv
// Bit-serial adder/subtractor. Operands are processed LSB first, one bit per
// clock through a single full adder, with the carry held in a flop between bits.
// Subtraction is A + ~B + 1: B is inverted on acceptance and the carry seeded with 1.
module serial_adder_unit
  import serial_adder_unit_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] result_o,
  output logic             carry_out_o,
  output logic             overflow_o
);

  localparam int unsigned CountW = count_width(Width);

  state_e              state_q, state_d;
  logic [Width-1:0]    a_sh_q, a_sh_d;
  logic [Width-1:0]    b_sh_q, b_sh_d;
  logic [Width-1:0]    result_q, result_d;
  logic [CountW-1:0]   cnt_q, cnt_d;
  logic                carry_q, carry_d;
  logic                carry_out_q, carry_out_d;
  logic                overflow_q, overflow_d;

  logic                fa_sum;
  logic                fa_carry;

  serial_adder_unit_full_adder u_full_adder (
    .a_i     (a_sh_q[0]),
    .b_i     (b_sh_q[0]),
    .c_i     (carry_q),
    .sum_o   (fa_sum),
    .carry_o (fa_carry)
  );

  // Next-state logic: accept in IDLE, shift one bit per cycle in RUN, hold in DONE.
  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    result_d    = result_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          a_sh_d   = a_i;
          b_sh_d   = (sub_i == OpSub) ? ~b_i : b_i;
          carry_d  = (sub_i == OpSub);
          cnt_d    = '0;
          result_d = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        // Sum bits enter at the MSB so that after Width shifts bit 0 sits at the LSB.
        result_d = result_q >> 1;
        result_d[Width-1] = fa_sum;
        carry_d  = fa_carry;
        cnt_d    = cnt_q + CountW'(1);
        if (cnt_q == CountW'(Width - 1)) begin
          carry_out_d = fa_carry;
          // carry_q is the carry into the MSB at this point.
          overflow_d  = carry_q ^ fa_carry;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  // Handshake flags decoded from state; data outputs straight from registers.
  always_comb begin
    in_ready_o  = (state_q == StIdle);
    out_valid_o = (state_q == StDone);
    result_o    = result_q;
    carry_out_o = carry_out_q;
    overflow_o  = overflow_q;
  end

endmodule

// File: tb/tb_serial_adder_unit.sv
// Bench for serial_adder_unit: directed Width=8 vectors with literal expectations,
// plus a Width=32 random regression, both checked every cycle against an
// arithmetic reference model.
module tb_serial_adder_unit;

  localparam int PhOff  = 0;
  localparam int PhRst  = 1;
  localparam int PhIdle = 2;
  localparam int PhBusy = 3;
  localparam int PhDone = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Width=8 instance signals
  logic       reset8 = 1'b1, in_valid8 = 1'b0, sub8 = 1'b0, out_ready8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       in_ready8, out_valid8, co8, ov8;
  logic [7:0] result8;

  // Width=32 instance signals
  logic        reset32 = 1'b1, in_valid32 = 1'b0, sub32 = 1'b0, out_ready32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        in_ready32, out_valid32, co32, ov32;
  logic [31:0] result32;

  serial_adder_unit #(.Width(8)) u_dut8 (
    .clk_i       (clk),
    .reset_i     (reset8),
    .in_valid_i  (in_valid8),
    .in_ready_o  (in_ready8),
    .a_i         (a8),
    .b_i         (b8),
    .sub_i       (sub8),
    .out_valid_o (out_valid8),
    .out_ready_i (out_ready8),
    .result_o    (result8),
    .carry_out_o (co8),
    .overflow_o  (ov8)
  );

  serial_adder_unit u_dut32 (
    .clk_i       (clk),
    .reset_i     (reset32),
    .in_valid_i  (in_valid32),
    .in_ready_o  (in_ready32),
    .a_i         (a32),
    .b_i         (b32),
    .sub_i       (sub32),
    .out_valid_o (out_valid32),
    .out_ready_i (out_ready32),
    .result_o    (result32),
    .carry_out_o (co32),
    .overflow_o  (ov32)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model state, one slot per instance (0: Width=8, 1: Width=32).
  int          ph[2]  = '{PhOff, PhOff};
  int          wd[2]  = '{8, 32};
  longint      acc[2];
  logic [63:0] er[2];
  logic        eco[2];
  logic        eov[2];

  // Expected outcome straight from arithmetic: A + B, or A - B as A + ~B + 1,
  // carry is bit Width of the wide sum, overflow from operand/result sign bits.
  task automatic model(input int d, input logic [63:0] a, input logic [63:0] b,
                       input logic s);
    int          w;
    logic [64:0] mask, bb, sum;
    w    = wd[d];
    mask = (65'd1 << w) - 65'd1;
    bb   = s ? (~{1'b0, b} & mask) : ({1'b0, b} & mask);
    sum  = ({1'b0, a} & mask) + bb + {64'd0, s};
    er[d]  = sum[63:0] & mask[63:0];
    eco[d] = sum[w];
    eov[d] = (a[w-1] == bb[w-1]) && (er[d][w-1] != a[w-1]);
  endtask

  task automatic mon(input int d, input logic rst, input logic iv, input logic ir,
                     input logic [63:0] a, input logic [63:0] b, input logic s,
                     input logic ovld, input logic ordy, input logic [63:0] r,
                     input logic co, input logic ovf);
    string tag;
    tag = (d == 0) ? "w8" : "w32";
    case (ph[d])
      PhRst: begin
        chk({tag, " reset in_ready"}, 64'(ir), 64'd1);
        chk({tag, " reset out_valid"}, 64'(ovld), 64'd0);
        chk({tag, " reset result"}, r, 64'd0);
        chk({tag, " reset carry_out"}, 64'(co), 64'd0);
        chk({tag, " reset overflow"}, 64'(ovf), 64'd0);
      end
      PhIdle: begin
        chk({tag, " idle in_ready"}, 64'(ir), 64'd1);
        chk({tag, " idle out_valid"}, 64'(ovld), 64'd0);
      end
      PhBusy: begin
        chk({tag, " busy in_ready"}, 64'(ir), 64'd0);
        chk({tag, " out_valid timing"}, 64'(ovld), 64'((cyc - acc[d]) == longint'(wd[d])));
      end
      default: ;
    endcase
    if ((ph[d] == PhDone) || (ph[d] == PhBusy && ovld)) begin
      chk({tag, " done out_valid"}, 64'(ovld), 64'd1);
      chk({tag, " done in_ready"}, 64'(ir), 64'd0);
      chk({tag, " result"}, r, er[d]);
      chk({tag, " carry_out"}, 64'(co), 64'(eco[d]));
      chk({tag, " overflow"}, 64'(ovf), 64'(eov[d]));
    end
    // Predict the phase after the coming edge; reset wins over everything.
    if (rst) begin
      ph[d] = PhRst;
    end else begin
      case (ph[d])
        PhRst, PhIdle: begin
          if (iv) begin
            model(d, a, b, s);
            acc[d] = cyc + 1;
            ph[d]  = PhBusy;
          end else begin
            ph[d] = PhIdle;
          end
        end
        PhBusy: if (ovld) ph[d] = ordy ? PhIdle : PhDone;
        PhDone: if (ordy) ph[d] = PhIdle;
        default: ;
      endcase
    end
  endtask

  // Compare process: sample both instances away from the active edge.
  always @(negedge clk) begin
    mon(0, reset8, in_valid8, in_ready8, 64'(a8), 64'(b8), sub8, out_valid8, out_ready8,
        64'(result8), co8, ov8);
    mon(1, reset32, in_valid32, in_ready32, 64'(a32), 64'(b32), sub32, out_valid32,
        out_ready32, 64'(result32), co32, ov32);
  end

  // One Width=8 operation with literal expectations; optional result stall and
  // optional different operands held on the input while busy.
  task automatic op8(input string nm, input logic [7:0] a, input logic [7:0] b,
                     input logic s, input int stall, input logic hold,
                     input logic [7:0] xr, input logic xco, input logic xov);
    int k;
    @(posedge clk); #1;
    a8 = a; b8 = b; sub8 = s; in_valid8 = 1'b1; out_ready8 = (stall == 0);
    k = 0;
    while (!in_ready8 && k < 50) begin @(posedge clk); #1; k++; end
    chk({nm, " accept wait"}, 64'(k < 50), 64'd1);
    @(posedge clk); #1;
    if (hold) begin
      a8 = ~a; b8 = b ^ 8'h5A; sub8 = ~s;
    end else begin
      in_valid8 = 1'b0;
    end
    k = 0;
    while (!out_valid8 && k < 40) begin @(posedge clk); #1; k++; end
    chk({nm, " out_valid wait"}, 64'(k < 40), 64'd1);
    chk({nm, " literal result"}, 64'(result8), 64'(xr));
    chk({nm, " literal carry_out"}, 64'(co8), 64'(xco));
    chk({nm, " literal overflow"}, 64'(ov8), 64'(xov));
    repeat (stall) begin @(posedge clk); #1; end
    out_ready8 = 1'b1; in_valid8 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic s,
                      input int stall);
    int k;
    @(posedge clk); #1;
    a32 = a; b32 = b; sub32 = s; in_valid32 = 1'b1; out_ready32 = (stall == 0);
    k = 0;
    while (!in_ready32 && k < 50) begin @(posedge clk); #1; k++; end
    @(posedge clk); #1;
    in_valid32 = 1'b0; a32 = $urandom; b32 = $urandom;
    k = 0;
    while (!out_valid32 && k < 80) begin @(posedge clk); #1; k++; end
    if (k >= 80) chk("w32 out_valid wait", 64'd0, 64'd1);
    repeat (stall) begin @(posedge clk); #1; end
    out_ready32 = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset8 = 1'b0; reset32 = 1'b0;

    op8("add 7f+01", 8'h7F, 8'h01, 1'b0, 0, 1'b0, 8'h80, 1'b0, 1'b1);
    op8("add ff+01", 8'hFF, 8'h01, 1'b0, 0, 1'b0, 8'h00, 1'b1, 1'b0);
    op8("sub 05-07", 8'h05, 8'h07, 1'b1, 0, 1'b0, 8'hFE, 1'b0, 1'b0);
    op8("sub 80-01", 8'h80, 8'h01, 1'b1, 0, 1'b0, 8'h7F, 1'b1, 1'b1);
    op8("sub 00-00", 8'h00, 8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b1, 1'b0);
    op8("stall 12+34", 8'h12, 8'h34, 1'b0, 5, 1'b1, 8'h46, 1'b0, 1'b0);

    // Reset after three bits of 0xAA+0x55 have been processed.
    @(posedge clk); #1;
    a8 = 8'hAA; b8 = 8'h55; sub8 = 1'b0; in_valid8 = 1'b1; out_ready8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset8 = 1'b1;
    @(posedge clk); #1;
    reset8 = 1'b0;
    chk("mid-op reset in_ready", 64'(in_ready8), 64'd1);
    chk("mid-op reset out_valid", 64'(out_valid8), 64'd0);
    chk("mid-op reset result", 64'(result8), 64'd0);
    chk("mid-op reset carry_out", 64'(co8), 64'd0);
    chk("mid-op reset overflow", 64'(ov8), 64'd0);
    op8("add 01+01", 8'h01, 8'h01, 1'b0, 0, 1'b0, 8'h02, 1'b0, 1'b0);

    // Width=32 regression: boundary operands first, then random mixed add/sub.
    op32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
    op32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1);
    op32(32'h8000_0000, 32'h0000_0001, 1'b1, 0);
    for (int i = 0; i < 1000; i++) begin
      op32($urandom, $urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
